// File: rtl/logic_func_sequencer.sv
// logic_func_sequencer
// Sweeps all 256 switch patterns through an external logic-function datapath,
// holds each pattern for SETTLE_CYC cycles, then compares the returned leds
// against the golden function for one cycle. The controller tracks the number
// of mismatching patterns and the first pattern that failed. Step mode pauses
// after every pattern until a step pulse. Abort cancels a sweep and keeps the
// error results.

module logic_func_sequencer #(
   parameter int unsigned SETTLE_CYC = 4   // legal range 1..255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       step_mode,
   input  logic       step,
   output logic [7:0] test_sw,
   input  logic [2:0] dut_led,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [8:0] err_cnt,
   output logic [7:0] first_err_pat,
   output logic       first_err_vld
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CHECK,
      ST_PAUSE,
      ST_DONE
   } state_t;

   // Terminal value of the settle counter: SETTLE_CYC cycles are spent in SETTLE.
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

   state_t     state;
   logic [7:0] pattern;
   logic [7:0] settle_cnt;
   logic [2:0] golden;
   logic       mismatch;

   // The datapath always sees the current pattern, in every state.
   assign test_sw = pattern;

   // Golden reference for the datapath, evaluated on the pattern under test.
   always_comb begin
      // NOTE: every output of an always_comb gets a default first so no path
      // leaves it unassigned; that is what keeps a latch from being inferred.
      golden    = '0;
      golden[0] = pattern[1] ^ pattern[0];
      golden[1] = pattern[3:1] inside {3'b000, 3'b011, 3'b101};
      golden[2] = pattern[7:4] inside {4'b0001, 4'b0011, 4'b0100, 4'b1111};
   end

   assign mismatch = (dut_led != golden);

   // Sweep controller: state, pattern, settle count, results and registered status.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: registers are written with <= so every flop in this block samples
      // the values from before the edge, independent of statement order.
      if (!rst_n) begin
         state         <= ST_IDLE;
         pattern       <= '0;
         settle_cnt    <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_cnt       <= '0;
         first_err_pat <= '0;
         first_err_vld <= 1'b0;
      end else if (abort) begin
         // Abort wins over start and step; results of the cancelled sweep stay visible.
         state      <= ST_IDLE;
         pattern    <= '0;
         settle_cnt <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state         <= ST_SETTLE;
                  pattern       <= '0;
                  settle_cnt    <= '0;
                  err_cnt       <= '0;
                  first_err_pat <= '0;
                  first_err_vld <= 1'b0;
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  pass          <= 1'b0;
               end
            end

            ST_SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state      <= ST_CHECK;
                  settle_cnt <= '0;
               end else begin
                  settle_cnt <= settle_cnt + 8'd1;
               end
            end

            ST_CHECK: begin
               if (mismatch) begin
                  // At most 256 patterns are checked, so 9 bits never overflow.
                  err_cnt <= err_cnt + 9'd1;
                  if (!first_err_vld) begin
                     first_err_pat <= pattern;
                     first_err_vld <= 1'b1;
                  end
               end
               if (pattern == 8'hFF) begin
                  // Last pattern: finish without wrapping; pass folds in this check.
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_cnt == 9'd0) && !mismatch;
               end else begin
                  pattern <= pattern + 8'd1;
                  state   <= step_mode ? ST_PAUSE : ST_SETTLE;
               end
            end

            ST_PAUSE: begin
               if (step) begin
                  state <= ST_SETTLE;
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               pass  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_logic_func_sequencer.sv
// Testbench for logic_func_sequencer.
// A behavioural datapath (correct, led[0] stuck-at-0, or random bit flips)
// answers the sequencer. Each sweep expected to complete pushes its predicted
// result into a queue; a monitor pops and compares whenever done rises.

module tb_logic_func_sequencer;

   localparam int S      = 4;
   localparam int PERIOD = S + 1;
   localparam int SWEEP  = 256 * PERIOD;

   typedef struct {
      logic [8:0] err;
      logic [7:0] fpat;
      logic       fvld;
      logic       pass;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       step_mode;
   logic       step;
   logic [7:0] test_sw;
   logic [2:0] dut_led;
   logic       busy;
   logic       done;
   logic       pass;
   logic [8:0] err_cnt;
   logic [7:0] first_err_pat;
   logic       first_err_vld;

   int         n_checks;
   int         n_err;
   int         fault_mode;
   logic [2:0] flip [256];
   exp_t       exp_q [$];
   logic       mon_done_q;

   logic_func_sequencer #(.SETTLE_CYC(S)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .abort         (abort),
      .step_mode     (step_mode),
      .step          (step),
      .test_sw       (test_sw),
      .dut_led       (dut_led),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_cnt       (err_cnt),
      .first_err_pat (first_err_pat),
      .first_err_vld (first_err_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference golden function, written from the truth-table rules.
   function automatic logic [2:0] ref_golden(input int p);
      int lo, mid, hi;
      logic [2:0] g;
      lo   = p % 4;
      mid  = (p / 2) % 8;
      hi   = p / 16;
      g[0] = (lo == 1) || (lo == 2);
      g[1] = (mid == 0) || (mid == 3) || (mid == 5);
      g[2] = (hi == 1) || (hi == 3) || (hi == 4) || (hi == 15);
      return g;
   endfunction

   // Behaviour of the external datapath for a given pattern.
   function automatic logic [2:0] model_led(input int p);
      logic [2:0] g;
      g = ref_golden(p);
      case (fault_mode)
         0:       return g;
         1:       return {g[2:1], 1'b0};
         default: return g ^ flip[p];
      endcase
   endfunction

   // Expected results after the patterns 0..upto-1 have been checked.
   function automatic exp_t predict(input int upto);
      exp_t e;
      e.err  = '0;
      e.fpat = '0;
      e.fvld = 1'b0;
      for (int p = 0; p < upto; p++) begin
         if (model_led(p) != ref_golden(p)) begin
            if (!e.fvld) begin
               e.fpat = 8'(p);
               e.fvld = 1'b1;
            end
            e.err = e.err + 9'd1;
         end
      end
      e.pass = (e.err == 0);
      return e;
   endfunction

   always_comb dut_led = model_led(int'(test_sw));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_test_sw"}, test_sw, 0);
      check({tag, "_busy"},    busy,    0);
      check({tag, "_done"},    done,    0);
      check({tag, "_pass"},    pass,    0);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic pulse_step();
      @(posedge clk); #1 step = 1'b1;
      @(posedge clk); #1 step = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) check({name, "_done_timeout"}, 0, 1);
   endtask

   task automatic new_flips(input int density);
      for (int p = 0; p < 256; p++)
         flip[p] = ($urandom_range(0, density) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
   endtask

   // Scoreboard monitor: compares results every time done rises.
   initial begin : monitor
      exp_t e;
      mon_done_q = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && done && !mon_done_q) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("sb_err_cnt",       err_cnt,       e.err);
               check("sb_first_err_pat", first_err_pat, e.fpat);
               check("sb_first_err_vld", first_err_vld, e.fvld);
               check("sb_pass",          pass,          e.pass);
            end
         end
         mon_done_q = done;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      exp_t e;
      bit   hit;
      n_checks   = 0;
      n_err      = 0;
      fault_mode = 0;
      for (int p = 0; p < 256; p++) flip[p] = 3'b000;
      rst_n     = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      step_mode = 1'b0;
      step      = 1'b0;

      // Reset asserted before any clock edge must clear everything at once.
      #3 rst_n = 1'b0;
      #1;
      check_idle_outputs("reset");
      check("reset_err_cnt", err_cnt,       0);
      check("reset_fpat",    first_err_pat, 0);
      check("reset_fvld",    first_err_vld, 0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("post_reset_busy",    busy,    0);
      check("post_reset_test_sw", test_sw, 0);

      // Free-run sweep with a correct datapath: exact timing and pattern walk.
      fault_mode = 0;
      exp_q.push_back(predict(256));
      pulse_start();
      for (int j = 0; j <= SWEEP; j++) begin
         if (j > 0) @(posedge clk);
         @(negedge clk);
         if (j < SWEEP) begin
            check("run_test_sw", test_sw, j / PERIOD);
            check("run_busy",    busy,    1);
            check("run_done",    done,    0);
         end else begin
            check("end_done",    done,    1);
            check("end_busy",    busy,    0);
            check("end_test_sw", test_sw, 8'hFF);
         end
         if (j == 500) start = 1'b1;   // start during a sweep is ignored
         if (j == 501) start = 1'b0;
      end
      repeat (10) @(negedge clk);
      check("hold_done",    done,    1);
      check("hold_pass",    pass,    1);
      check("hold_err_cnt", err_cnt, 0);

      // Restart from DONE with led[0] stuck at 0.
      fault_mode = 1;
      exp_q.push_back(predict(256));
      pulse_start();
      wait_done(SWEEP + 20, "stuck");

      // Random datapath faults, free-running.
      for (int r = 0; r < 2; r++) begin
         fault_mode = 2;
         new_flips($urandom_range(3, 40));
         exp_q.push_back(predict(256));
         pulse_start();
         wait_done(SWEEP + 20, "rand_free");
      end

      // Random faults in step mode with random step spacing.
      fault_mode = 2;
      new_flips(10);
      exp_q.push_back(predict(256));
      step_mode = 1'b1;
      pulse_start();
      for (int p = 0; p < 255; p++) begin
         repeat (PERIOD + $urandom_range(0, 3)) @(posedge clk);
         #1 step = 1'b1;
         @(posedge clk); #1 step = 1'b0;
      end
      wait_done(PERIOD + 20, "rand_step");
      step_mode = 1'b0;

      // Step mode without step pulses: holds in PAUSE; each step advances by one.
      fault_mode = 0;
      step_mode  = 1'b1;
      pulse_start();
      repeat (PERIOD + 20) @(negedge clk);
      check("pause_test_sw", test_sw, 1);
      check("pause_busy",    busy,    1);
      for (int i = 0; i < 3; i++) begin
         pulse_step();
         pulse_step();                  // lands in SETTLE and is ignored
         repeat (PERIOD + 6) @(negedge clk);
         check("step_test_sw", test_sw, 2 + i);
         check("step_busy",    busy,    1);
      end
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      step_mode = 1'b0;

      // Abort at pattern 100 keeps the error results.
      fault_mode = 1;
      e = predict(100);
      pulse_start();
      hit = 1'b0;
      for (int i = 0; i < 110 * PERIOD && !hit; i++) begin
         @(negedge clk);
         if (test_sw == 8'd100) hit = 1'b1;
      end
      check("abort_reached_100", hit, 1);
      abort = 1'b1;
      step  = 1'b1;
      @(posedge clk); #1 abort = 1'b0; step = 1'b0;
      @(negedge clk);
      check_idle_outputs("abort");
      check("abort_err_cnt", err_cnt,       e.err);
      check("abort_fpat",    first_err_pat, e.fpat);
      check("abort_fvld",    first_err_vld, e.fvld);
      repeat (PERIOD * 2) @(negedge clk);
      check("abort_stays_idle", busy, 0);

      // Start and abort together in IDLE: stays in IDLE.
      @(posedge clk); #1 start = 1'b1; abort = 1'b1;
      @(posedge clk); #1 start = 1'b0; abort = 1'b0;
      @(negedge clk);
      check("start_abort_busy",    busy,    0);
      check("start_abort_err_cnt", err_cnt, e.err);
      repeat (3) @(negedge clk);
      check("start_abort_still_idle", busy, 0);

      // Asynchronous reset mid-SETTLE, then a full sweep.
      fault_mode = 2;
      new_flips(6);
      pulse_start();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      check("async_reset_err_cnt", err_cnt,       0);
      check("async_reset_fpat",    first_err_pat, 0);
      check("async_reset_fvld",    first_err_vld, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("async_release_busy",    busy,    0);
      check("async_release_test_sw", test_sw, 0);
      exp_q.push_back(predict(256));
      pulse_start();
      wait_done(SWEEP + 20, "after_reset");

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
